board_input_conditioner: RTL and testbench
==========================================

// Module: board_input_conditioner
// PURPOSE
//  Upstream conditioning stage between raw board pins (button, slide switches) and the
//  sigma SoC inputs irq_btn_i / gpio_bi. Synchronises each pin into clk_i and debounces it.
//  Produces one fixed-length IRQ pulse per debounced button press.
//  Produces a glitch-free switch vector with a change strobe. Sits in the board top.
// PARAMETERS
//  NUM_SW          16      number of switch inputs
//  DEBOUNCE_CYCLES 250000  consecutive cycles an input must differ from its stable value before it is accepted (>=2)
//  IRQ_PULSE_LEN   4       cycles irq_btn_o stays high per press (>=1)
// PORTS
//  clk_i       in   1       system clock (PLL output)
//  arst_n_i    in   1       asynchronous active-low reset
//  btn_i       in   1       raw button, active high, asynchronous to clk_i
//  sw_i        in   NUM_SW  raw switches, asynchronous to clk_i
//  btn_level_o out  1       debounced button level
//  irq_btn_o   out  1       press interrupt pulse, to sigma irq_btn_i
//  sw_o        out  NUM_SW  debounced switch vector, to gpio_bi
//  sw_chg_o    out  1       one-cycle strobe: sw_o changed this cycle
// BEHAVIOUR
//  Reset: all sync flops, stable values, counters -> 0; FSM -> IDLE.
//   All outputs are 0 while arst_n_i is low. Reset is asserted asynchronously and released synchronously by the board top.
//  Sync: each of the NUM_SW+1 inputs passes a 2-flop synchroniser; only the 2nd flop is used.
//  Debounce, per input, independent:
//   - cnt width = $clog2(DEBOUNCE_CYCLES).
//   - synced == stable -> cnt <= 0.
//   - synced != stable and cnt < DEBOUNCE_CYCLES-1 -> cnt <= cnt+1.
//   - synced != stable and cnt == DEBOUNCE_CYCLES-1 -> stable <= synced, cnt <= 0.
//   - Any return to the stable value before acceptance restarts the count; there is no partial credit.
//   - Latency: a clean input change sampled at edge 0 appears on the output after edge DEBOUNCE_CYCLES+1,
//     i.e. DEBOUNCE_CYCLES+2 edges total.
//  btn_level_o = button stable value. sw_o = switch stable values (registered).
//  sw_chg_o = 1 in exactly the cycle in which at least one sw_o bit first shows a new value.
//   Simultaneous bit updates give a single strobe. Updates in consecutive cycles give consecutive strobes.
//  IRQ FSM (states IDLE, PULSE, WAIT_REL; pulse counter width $clog2(IRQ_PULSE_LEN+1)):
//   - IDLE: btn_level_o rises (0 in previous cycle, 1 now) -> PULSE, pcnt <= 0.
//   - PULSE: irq_btn_o=1. pcnt increments; at pcnt==IRQ_PULSE_LEN-1 -> WAIT_REL.
//     The pulse begins the cycle after btn_level_o rises and lasts exactly IRQ_PULSE_LEN cycles.
//   - WAIT_REL: irq_btn_o=0. btn_level_o==0 -> IDLE. No further IRQ until a debounced release.
//   - A release during PULSE does not shorten the pulse; FSM still goes to WAIT_REL, then IDLE next cycle.
//  irq_btn_o is a registered FSM output, so it is glitch-free.
//  Reset mid-operation: outputs drop immediately. If the button is still held at reset release,
//   it is debounced from 0 again and produces a new IRQ pulse.
//  No combinational path from any input to any output.
// TESTING (DEBOUNCE_CYCLES=8, IRQ_PULSE_LEN=4, NUM_SW=16)
//  1 Reset: arst_n_i=0 with btn_i=1, sw_i=16'hFFFF -> all outputs 0 throughout reset.
//  2 Clean press: btn_i 0->1 before edge 0 -> btn_level_o=1 after edge 9; irq_btn_o=1 after edges 10..13
//    (exactly 4 cycles), 0 after.
//  3 Bounce: btn_i toggles every 3 cycles for 30 cycles, then holds 1 -> btn_level_o stays 0 until
//    10 edges after the last toggle; exactly one 4-cycle irq pulse.
//  4 Hold 200 cycles -> single irq. Release, wait 20, press again -> second irq.
//    1-cycle dips on btn_i while held -> no extra irq.
//  5 Switches: sw_i 16'h0000->16'h00A5 -> sw_o=16'h00A5 after 10 edges with one sw_chg_o cycle.
//    A 5-cycle glitch on sw_i[3] -> sw_o unchanged, sw_chg_o stays 0.
//  6 Reset during PULSE with btn_i held -> irq_btn_o drops asynchronously.
//    After release: new btn_level_o rise 10 edges later and a fresh 4-cycle irq pulse.

Source files
------------

// File: rtl/board_input_conditioner.sv
// rtl/board_input_conditioner.sv - synchronise, debounce and IRQ-pulse board button and switch pins
module board_input_conditioner #(
    parameter int NUM_SW          = 16,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int IRQ_PULSE_LEN   = 4
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              btn_i,
    input  logic [NUM_SW-1:0] sw_i,
    output logic              btn_level_o,
    output logic              irq_btn_o,
    output logic [NUM_SW-1:0] sw_o,
    output logic              sw_chg_o
);
    localparam int N  = NUM_SW + 1;
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int PW = $clog2(IRQ_PULSE_LEN + 1);

    typedef enum logic [1:0] {IDLE, PULSE, WAIT_REL} state_t;

    // Bit NUM_SW carries the button, the lower bits the switches.
    logic [N-1:0]  raw, sync1, sync2, stable, stable_next;
    logic [CW-1:0] cnt      [N];
    logic [CW-1:0] cnt_next [N];
    logic          sw_chg, btn_prev, irq;
    logic          btn_rise;
    state_t        state, state_next;
    logic [PW-1:0] pcnt, pcnt_next;

    assign raw = {btn_i, sw_i};

    always_comb begin
        stable_next = stable;
        for (int i = 0; i < N; i++) begin
            cnt_next[i] = '0;
            if (sync2[i] != stable[i]) begin
                if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1))
                    stable_next[i] = sync2[i];
                else
                    cnt_next[i] = cnt[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            sw_chg   <= 1'b0;
            btn_prev <= 1'b0;
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable   <= stable_next;
            // Strobe lands in the same cycle the new switch value becomes visible.
            sw_chg   <= (stable_next[NUM_SW-1:0] != stable[NUM_SW-1:0]);
            btn_prev <= stable[NUM_SW];
            for (int i = 0; i < N; i++) cnt[i] <= cnt_next[i];
        end
    end

    assign btn_rise = stable[NUM_SW] & ~btn_prev;

    always_comb begin
        state_next = state;
        pcnt_next  = pcnt;
        case (state)
            IDLE: begin
                if (btn_rise) begin
                    state_next = PULSE;
                    pcnt_next  = '0;
                end
            end
            PULSE: begin
                pcnt_next = pcnt + PW'(1);
                if (pcnt == PW'(IRQ_PULSE_LEN - 1)) state_next = WAIT_REL;
            end
            WAIT_REL: begin
                if (!stable[NUM_SW]) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state <= IDLE;
            pcnt  <= '0;
            irq   <= 1'b0;
        end else begin
            state <= state_next;
            pcnt  <= pcnt_next;
            irq   <= (state_next == PULSE);
        end
    end

    assign btn_level_o = stable[NUM_SW];
    assign sw_o        = stable[NUM_SW-1:0];
    assign sw_chg_o    = sw_chg;
    assign irq_btn_o   = irq;
endmodule

// File: tb/tb_board_input_conditioner.sv
// tb/tb_board_input_conditioner.sv - directed self-checking bench for board_input_conditioner
module tb_board_input_conditioner;
    logic        clk = 1'b0;
    logic        arst_n;
    logic        btn;
    logic [15:0] sw;
    logic        btn_level, irq, sw_chg;
    logic [15:0] sw_out;

    int total = 0;
    int bad   = 0;
    int cnt_a, cnt_b, first_k, chg_k, found;

    board_input_conditioner #(
        .NUM_SW(16), .DEBOUNCE_CYCLES(8), .IRQ_PULSE_LEN(4)
    ) dut (
        .clk_i(clk), .arst_n_i(arst_n), .btn_i(btn), .sw_i(sw),
        .btn_level_o(btn_level), .irq_btn_o(irq), .sw_o(sw_out), .sw_chg_o(sw_chg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        arst_n = 1'b0; btn = 1'b1; sw = 16'hFFFF;
        // 1: outputs held at zero through reset with all pins high
        step(3);
        chk("rst_level", btn_level, 0);
        chk("rst_irq", irq, 0);
        chk("rst_sw", sw_out, 0);
        step(12);
        chk("rst_all_late", {btn_level, irq, sw_chg, sw_out}, 0);
        btn = 1'b0; sw = 16'h0000;
        step(1);
        arst_n = 1'b1;
        step(5);
        chk("post_rst", {btn_level, irq, sw_chg, sw_out}, 0);

        // 2: clean press
        btn = 1'b1;
        step(9);
        chk("press_lvl_e8", btn_level, 0);
        step(1);
        chk("press_lvl_e9", btn_level, 1);
        chk("press_irq_e9", irq, 0);
        cnt_a = 0;
        for (int k = 0; k < 4; k++) begin
            step(1);
            cnt_a += int'(irq);
        end
        chk("press_irq_len", cnt_a, 4);
        step(1);
        chk("press_irq_e14", irq, 0);
        btn = 1'b0;
        step(12);
        chk("release_lvl", btn_level, 0);

        // 3: bouncing press
        cnt_a = 0; cnt_b = 0;
        for (int t = 0; t < 10; t++) begin
            btn = ~btn;
            for (int c = 0; c < 3; c++) begin
                step(1);
                cnt_a += int'(irq);
                cnt_b += int'(btn_level);
            end
        end
        chk("bounce_irq_none", cnt_a, 0);
        chk("bounce_lvl_low", cnt_b, 0);
        btn = 1'b1;
        step(9);
        chk("bounce_lvl_e8", btn_level, 0);
        step(1);
        chk("bounce_lvl_e9", btn_level, 1);
        cnt_a = 0;
        for (int c = 0; c < 12; c++) begin
            step(1);
            cnt_a += int'(irq);
        end
        chk("bounce_irq_len", cnt_a, 4);

        // 4: long hold with dips, then second press
        btn = 1'b0;
        step(20);
        chk("h_release", btn_level, 0);
        btn = 1'b1;
        cnt_a = 0;
        for (int k = 0; k < 200; k++) begin
            btn = (k == 50 || k == 120) ? 1'b0 : 1'b1;
            step(1);
            cnt_a += int'(irq);
        end
        chk("hold_single_irq", cnt_a, 4);
        chk("hold_lvl", btn_level, 1);
        btn = 1'b0;
        cnt_a = 0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            cnt_a += int'(irq);
        end
        chk("hold_rel_irq", cnt_a, 0);
        chk("hold_rel_lvl", btn_level, 0);
        btn = 1'b1;
        cnt_a = 0;
        for (int k = 0; k < 30; k++) begin
            step(1);
            cnt_a += int'(irq);
        end
        chk("second_irq", cnt_a, 4);
        btn = 1'b0;
        step(20);

        // 5: switch vector, glitch, consecutive updates
        sw = 16'h00A5;
        first_k = 0; chg_k = 0; cnt_a = 0;
        for (int k = 1; k <= 14; k++) begin
            step(1);
            if (sw_out == 16'h00A5 && first_k == 0) first_k = k;
            if (sw_chg) chg_k = k;
            cnt_a += int'(sw_chg);
        end
        chk("sw_latency", first_k, 10);
        chk("sw_chg_cnt", cnt_a, 1);
        chk("sw_chg_when", chg_k, 10);
        sw[3] = 1'b1;
        step(5);
        sw[3] = 1'b0;
        cnt_a = 0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            cnt_a += int'(sw_chg);
        end
        chk("glitch_sw", sw_out, 16'h00A5);
        chk("glitch_chg", cnt_a, 0);
        sw = 16'h00A4;
        step(1);
        sw = 16'h00A0;
        cnt_a = 0; first_k = 0; chg_k = 0;
        for (int k = 1; k <= 14; k++) begin
            step(1);
            if (sw_chg && first_k == 0) first_k = k;
            if (sw_chg) chg_k = k;
            cnt_a += int'(sw_chg);
        end
        chk("consec_chg_cnt", cnt_a, 2);
        chk("consec_chg_adj", chg_k - first_k, 1);
        chk("consec_sw", sw_out, 16'h00A0);

        // 6: reset in the middle of a pulse with button held
        btn = 1'b1;
        found = 0;
        for (int k = 0; k < 30 && found == 0; k++) begin
            step(1);
            if (irq) found = 1;
        end
        chk("r6_irq_seen", found, 1);
        step(1);
        #2 arst_n = 1'b0;
        #1;
        chk("r6_irq_async", irq, 0);
        chk("r6_all_async", {btn_level, sw_chg, sw_out}, 0);
        step(3);
        arst_n = 1'b1;
        step(9);
        chk("r6_lvl_e8", btn_level, 0);
        step(1);
        chk("r6_lvl_e9", btn_level, 1);
        cnt_a = 0;
        for (int k = 0; k < 4; k++) begin
            step(1);
            cnt_a += int'(irq);
        end
        chk("r6_irq_len", cnt_a, 4);
        step(1);
        chk("r6_irq_end", irq, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
